// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath blocks.
`timescale 1ns/1ps
package nn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int CFG_NUM_W = 32;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up-counter; wrap flags the increment that returns it to zero.
`timescale 1ns/1ps
module wrap_counter #(
    parameter int MAX   = 3,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == WIDTH'(MAX - 1));
    assign wrap    = inc && at_last;
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/neuron_weight_seq.sv
// Weight sequencer for one neuron: turns matched config words into memory writes
// and activations into memory reads, pairing each activation with its weight.
`timescale 1ns/1ps
module neuron_weight_seq
    import nn_pkg::*;
#(
    parameter int numWeight    = 3,
    parameter int neuronNo     = 5,
    parameter int layerNo      = 1,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    weightValid,
    input  logic [dataWidth-1:0]    weightValue,
    input  logic [CFG_NUM_W-1:0]    config_layer_num,
    input  logic [CFG_NUM_W-1:0]    config_neuron_num,
    input  logic                    myinputValid,
    input  logic [dataWidth-1:0]    myinput,
    output logic                    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    output logic                    op_valid,
    output logic [dataWidth-1:0]    op_x,
    output logic [dataWidth-1:0]    op_w,
    output logic                    op_last,
    output logic                    load_done,
    output logic                    busy,
    output logic                    cfg_err
);

    seq_state_t             state_q, state_d;
    logic                   match;
    logic                   w_wrap, r_wrap;
    logic [addressWidth-1:0] w_cnt, r_cnt;
    logic [dataWidth-1:0]   x_q;
    logic                   v_q, l_q, load_done_q, cfg_err_q;

    assign match = weightValid
                && (config_layer_num  == CFG_NUM_W'(layerNo))
                && (config_neuron_num == CFG_NUM_W'(neuronNo));

    // Writes are refused while a vector is being read, so a weight never
    // changes underneath an in-flight multiply.
    assign busy = (state_q == RUN) || myinputValid;
    assign wen  = match && !busy;
    assign wadd = w_cnt;
    assign win  = weightValue;

    assign ren  = myinputValid;
    assign radd = r_cnt;

    wrap_counter #(.MAX(numWeight), .WIDTH(addressWidth)) u_w_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wen),
        .cnt   (w_cnt),
        .wrap  (w_wrap)
    );

    wrap_counter #(.MAX(numWeight), .WIDTH(addressWidth)) u_r_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (myinputValid),
        .cnt   (r_cnt),
        .wrap  (r_wrap)
    );

    // A single-weight vector completes on its first beat and never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (myinputValid && !r_wrap) state_d = RUN;
            RUN:     if (myinputValid &&  r_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            v_q         <= 1'b0;
            l_q         <= 1'b0;
            load_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= myinput;
            v_q         <= myinputValid;
            l_q         <= r_wrap;
            load_done_q <= w_wrap;
            cfg_err_q   <= cfg_err_q || (match && busy);
        end
    end

    assign op_x      = x_q;
    assign op_valid  = v_q;
    assign op_last   = l_q;
    assign op_w      = wout;
    assign load_done = load_done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_neuron_weight_seq.sv
// Directed bench for neuron_weight_seq with a small registered-read weight memory.
`timescale 1ns/1ps
module tb_neuron_weight_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        weightValid;
    logic [15:0] weightValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        myinputValid;
    logic [15:0] myinput;
    logic        wen, ren;
    logic [9:0]  wadd, radd;
    logic [15:0] win, wout;
    logic        op_valid, op_last, load_done, busy, cfg_err;
    logic [15:0] op_x, op_w;

    logic [15:0] mem [0:3];
    logic [15:0] wts [0:2];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_weight_seq dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .weightValid       (weightValid),
        .weightValue       (weightValue),
        .config_layer_num  (config_layer_num),
        .config_neuron_num (config_neuron_num),
        .myinputValid      (myinputValid),
        .myinput           (myinput),
        .wen               (wen),
        .wadd              (wadd),
        .win               (win),
        .ren               (ren),
        .radd              (radd),
        .wout              (wout),
        .op_valid          (op_valid),
        .op_x              (op_x),
        .op_w              (op_w),
        .op_last           (op_last),
        .load_done         (load_done),
        .busy              (busy),
        .cfg_err           (cfg_err)
    );

    always @(posedge clk) begin
        if (wen)  mem[wadd[1:0]] <= win;
        if (ren)  wout <= mem[radd[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 16'h0;
        wout = 16'h0;
        wts[0] = 16'h0011; wts[1] = 16'h0022; wts[2] = 16'h0033;
        rst_n = 1'b0;
        weightValid = 1'b0; weightValue = 16'h0;
        config_layer_num = 32'd1; config_neuron_num = 32'd5;
        myinputValid = 1'b0; myinput = 16'h0;
        tick(); tick();
        chk("rst_op_valid", {31'b0, op_valid}, 0);
        chk("rst_op_last",  {31'b0, op_last}, 0);
        chk("rst_op_x",     {16'b0, op_x}, 0);
        chk("rst_wen",      {31'b0, wen}, 0);
        chk("rst_ren",      {31'b0, ren}, 0);
        chk("rst_radd",     {22'b0, radd}, 0);
        chk("rst_wadd",     {22'b0, wadd}, 0);
        chk("rst_load_done",{31'b0, load_done}, 0);
        chk("rst_cfg_err",  {31'b0, cfg_err}, 0);
        rst_n = 1'b1;
        tick();

        // Mismatched neuron number
        weightValid = 1'b1; config_neuron_num = 32'd4; weightValue = 16'h00EE;
        #1 chk("mis_wen", {31'b0, wen}, 0);
        tick();
        weightValid = 1'b0; config_neuron_num = 32'd5;
        #1 chk("mis_wadd", {22'b0, wadd}, 0);
        chk("mis_cfg_err", {31'b0, cfg_err}, 0);

        // Load three weights back-to-back
        for (int i = 0; i < 3; i++) begin
            weightValid = 1'b1; weightValue = wts[i];
            #1;
            chk("ld_wen",  {31'b0, wen}, 1);
            chk("ld_wadd", {22'b0, wadd}, i);
            chk("ld_win",  {16'b0, win}, {16'b0, wts[i]});
            tick();
            chk("ld_done", {31'b0, load_done}, (i == 2) ? 1 : 0);
        end
        weightValid = 1'b0;
        #1 chk("ld_wadd_wrap", {22'b0, wadd}, 0);
        tick();
        chk("ld_done_pulse", {31'b0, load_done}, 0);

        // Back-to-back vector
        for (int i = 0; i < 3; i++) begin
            myinputValid = 1'b1; myinput = 16'(i + 1);
            #1;
            chk("cv_ren",  {31'b0, ren}, 1);
            chk("cv_radd", {22'b0, radd}, i);
            tick();
            chk("cv_valid", {31'b0, op_valid}, 1);
            chk("cv_x",     {16'b0, op_x}, i + 1);
            chk("cv_w",     {16'b0, op_w}, {16'b0, wts[i]});
            chk("cv_last",  {31'b0, op_last}, (i == 2) ? 1 : 0);
        end
        myinputValid = 1'b0;
        #1 chk("cv_busy_drop", {31'b0, busy}, 0);
        tick();
        chk("cv_valid_off", {31'b0, op_valid}, 0);

        // Two gapped vectors
        for (int i = 0; i < 6; i++) begin
            myinputValid = 1'b1; myinput = 16'(16'h40 + i);
            #1 chk("gp_radd", {22'b0, radd}, i % 3);
            tick();
            chk("gp_x",    {16'b0, op_x}, 16'h40 + i);
            chk("gp_w",    {16'b0, op_w}, {16'b0, wts[i % 3]});
            chk("gp_last", {31'b0, op_last}, (i % 3 == 2) ? 1 : 0);
            myinputValid = 1'b0;
            #1 chk("gp_busy", {31'b0, busy}, (i % 3 == 2) ? 0 : 1);
            for (int g = 0; g < 2; g++) begin
                tick();
                chk("gp_gap_valid", {31'b0, op_valid}, 0);
            end
        end

        // Collision: config word during the second activation
        myinputValid = 1'b1; myinput = 16'h7;
        tick();
        myinput = 16'h8; weightValid = 1'b1; weightValue = 16'h0099;
        #1;
        chk("col_wen", {31'b0, wen}, 0);
        tick();
        chk("col_cfg_err", {31'b0, cfg_err}, 1);
        chk("col_w1", {16'b0, op_w}, 16'h0022);
        weightValid = 1'b0; myinput = 16'h9;
        #1 chk("col_wadd", {22'b0, wadd}, 0);
        tick();
        chk("col_last", {31'b0, op_last}, 1);
        chk("col_w2",   {16'b0, op_w}, 16'h0033);
        myinputValid = 1'b0;
        tick(); tick();
        chk("col_err_held", {31'b0, cfg_err}, 1);

        // Reset in the middle of a vector
        myinputValid = 1'b1; myinput = 16'h5;
        tick();
        myinputValid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_op_valid", {31'b0, op_valid}, 0);
        chk("mr_op_x",     {16'b0, op_x}, 0);
        chk("mr_radd",     {22'b0, radd}, 0);
        chk("mr_cfg_err",  {31'b0, cfg_err}, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        myinputValid = 1'b1; myinput = 16'hA;
        #1 chk("mr_next_radd", {22'b0, radd}, 0);
        tick();
        chk("mr_next_w", {16'b0, op_w}, 16'h0011);
        chk("mr_next_x", {16'b0, op_x}, 16'h000A);
        myinputValid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
